// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//
// Instruction fetch stage of the five-stage pipeline. Owns the PC, issues word
// requests to instruction memory over a req/ack handshake and writes the IF/ID
// pipeline register. Honours stalls from the hazard logic and branch redirects
// from MEM, inserting NOP bubbles where needed.
//
// Ports:
//   clock          system clock, all state updates on the rising edge
//   reset          synchronous, active-low reset
//   stall          hold IF/ID and PC
//   branch_taken   redirect request from MEM
//   branch_target  redirect byte address (low two bits are ignored)
//   imem_req       instruction memory request valid
//   imem_addr      word-aligned fetch address
//   imem_ack       read data valid; may arrive in the same cycle as imem_req
//   imem_rdata     instruction word, valid when imem_ack=1
//   PR_IFID_Inst   IF/ID instruction register
//   PR_IFID_PC4    IF/ID PC+4 of the held instruction
//   PR_IFID_Valid  1 = PR_IFID_Inst is a real instruction, 0 = bubble
//   fetch_busy     1 while in HOLD or DROP
// -----------------------------------------------------------------------------
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PR_IFID_Inst,
  output logic [31:0] PR_IFID_PC4,
  output logic        PR_IFID_Valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  // pc_reg is the next instruction to deliver; addr_reg is what is on the bus.
  // They differ only in DROP, where the bus must keep the abandoned address
  // until the memory acknowledges it while pc_reg already holds the target.
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  // Keeps imem_req low for the first cycle after reset releases.
  logic        started_reg;
  logic [31:0] skid_inst_reg, skid_inst_next;
  logic [31:0] skid_pc4_reg, skid_pc4_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;

  logic        req;
  logic        xfer;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign req            = started_reg && (state_reg != ST_HOLD);
  assign xfer           = req && imem_ack;
  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = branch_target & ~32'd3;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      addr_reg       <= RESET_PC;
      started_reg    <= 1'b0;
      skid_inst_reg  <= NOP_INST;
      skid_pc4_reg   <= 32'd0;
      skid_valid_reg <= 1'b0;
      inst_reg       <= NOP_INST;
      pc4_reg        <= 32'd0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      addr_reg       <= addr_next;
      started_reg    <= 1'b1;
      skid_inst_reg  <= skid_inst_next;
      skid_pc4_reg   <= skid_pc4_next;
      skid_valid_reg <= skid_valid_next;
      inst_reg       <= inst_next;
      pc4_reg        <= pc4_next;
      valid_reg      <= valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    addr_next       = addr_reg;
    skid_inst_next  = skid_inst_reg;
    skid_pc4_next   = skid_pc4_reg;
    skid_valid_next = skid_valid_reg;
    inst_next       = inst_reg;
    pc4_next        = pc4_reg;
    valid_next      = valid_reg;

    case (state_reg)
      ST_FETCH: begin
        if (branch_taken) begin
          inst_next       = NOP_INST;
          valid_next      = 1'b0;
          pc_next         = target_aligned;
          skid_valid_next = 1'b0;
          if (xfer || !req) begin
            // Nothing left in flight: the target goes out next cycle.
            addr_next  = target_aligned;
            state_next = ST_FETCH;
          end else begin
            // Outstanding request must still be completed and thrown away.
            state_next = ST_DROP;
          end
        end else if (xfer) begin
          pc_next   = pc_plus4;
          addr_next = pc_plus4;
          if (stall) begin
            skid_inst_next  = imem_rdata;
            skid_pc4_next   = pc_plus4;
            skid_valid_next = 1'b1;
            state_next      = ST_HOLD;
          end else begin
            inst_next  = imem_rdata;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
          end
        end else if (!stall) begin
          inst_next  = NOP_INST;
          valid_next = 1'b0;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          inst_next       = NOP_INST;
          valid_next      = 1'b0;
          pc_next         = target_aligned;
          addr_next       = target_aligned;
          skid_valid_next = 1'b0;
          state_next      = ST_FETCH;
        end else if (!stall) begin
          inst_next       = skid_inst_reg;
          pc4_next        = skid_pc4_reg;
          valid_next      = skid_valid_reg;
          skid_valid_next = 1'b0;
          state_next      = ST_FETCH;
        end
      end

      ST_DROP: begin
        inst_next  = NOP_INST;
        valid_next = 1'b0;
        if (branch_taken) begin
          pc_next = target_aligned;
          // If the old request completes in this same cycle there is nothing
          // left to wait for, so fetch the newest target straight away.
          if (xfer) begin
            addr_next  = target_aligned;
            state_next = ST_FETCH;
          end
        end else if (xfer) begin
          addr_next  = pc_reg;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  assign imem_req      = req;
  assign imem_addr     = addr_reg;
  assign PR_IFID_Inst  = inst_reg;
  assign PR_IFID_PC4   = pc4_reg;
  assign PR_IFID_Valid = valid_reg;
  assign fetch_busy    = (state_reg == ST_HOLD) || (state_reg == ST_DROP);

endmodule

// File: tb/tb_inst_fetch_stage.sv
module tb_inst_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PR_IFID_Inst;
  logic [31:0] PR_IFID_PC4;
  logic        PR_IFID_Valid;
  logic        fetch_busy;

  // memory model controls
  logic auto_mem;
  logic man_ack;
  int   lat;
  int   held_cnt;

  int errors   = 0;
  int checks   = 0;
  int xfer_cnt = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];   // {inst, pc4}

  always #5 clock = ~clock;

  inst_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PR_IFID_Inst (PR_IFID_Inst),
    .PR_IFID_PC4  (PR_IFID_PC4),
    .PR_IFID_Valid(PR_IFID_Valid),
    .fetch_busy   (fetch_busy)
  );

  assign imem_rdata = imem_addr | 32'h2000_0000;
  assign imem_ack   = auto_mem ? (imem_req && (held_cnt >= lat - 1)) : man_ack;

  // cycles the current request has waited
  always @(posedge clock) begin
    if (!reset)                     held_cnt <= 0;
    else if (imem_req && imem_ack)  held_cnt <= 0;
    else if (imem_req)              held_cnt <= held_cnt + 1;
    else                            held_cnt <= 0;
  end

  // monitor: pops expected transfers and IF/ID deliveries
  initial begin
    logic        pv;
    logic [31:0] pi;
    logic [31:0] pp;
    logic [31:0] ea;
    logic [63:0] eo;
    pv = 1'b0; pi = 32'd0; pp = 32'd0;
    forever begin
      @(negedge clock);
      if (reset && imem_req && imem_ack) begin
        xfer_cnt++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_addr: got %h, no transfer expected", imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (imem_addr !== ea) begin
            errors++;
            $display("FAIL xfer_addr: got %h, expected %h", imem_addr, ea);
          end else
            $display("xfer addr=%h", imem_addr);
        end
      end
      if (PR_IFID_Valid && (!pv || PR_IFID_Inst != pi || PR_IFID_PC4 != pp)) begin
        checks++;
        if (exp_out_q.size() == 0) begin
          errors++;
          $display("FAIL ifid: got inst=%h pc4=%h, no delivery expected", PR_IFID_Inst, PR_IFID_PC4);
        end else begin
          eo = exp_out_q.pop_front();
          if ({PR_IFID_Inst, PR_IFID_PC4} !== eo) begin
            errors++;
            $display("FAIL ifid: got inst=%h pc4=%h, expected inst=%h pc4=%h",
                     PR_IFID_Inst, PR_IFID_PC4, eo[63:32], eo[31:0]);
          end else
            $display("ifid inst=%h pc4=%h", PR_IFID_Inst, PR_IFID_PC4);
        end
      end
      pv = PR_IFID_Valid; pi = PR_IFID_Inst; pp = PR_IFID_PC4;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_xfers(input int n);
    int budget;
    budget = 200;
    while (xfer_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    if (xfer_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: got %0d transfers, expected %0d", xfer_cnt, n);
    end
  endtask

  task automatic push_xfer(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] inst, input logic [31:0] pc4);
    exp_out_q.push_back({inst, pc4});
  endtask

  // linear zero-based run: addresses base, base+4, ...
  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_xfer(base + 32'(4 * i));
      push_out((base + 32'(4 * i)) | 32'h2000_0000, base + 32'(4 * i + 4));
    end
  endtask

  task automatic do_reset();
    auto_mem = 1'b0; man_ack = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; lat = 1;
    reset = 1'b0;
    tick();
    tick();
    xfer_cnt = 0;
    reset = 1'b1;
  endtask

  task automatic drain_and_check(input string name);
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    tick(); tick(); tick();
    chk({name, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_out_q_empty"},  32'(exp_out_q.size()),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values, zero-wait streaming ----------------
    auto_mem = 1'b0; man_ack = 1'b0; stall = 1'b0; lat = 1;
    branch_taken = 1'b0; branch_target = 32'd0;
    reset = 1'b0;
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req},      32'd0);
    chk("rst_addr",  imem_addr,              32'd0);
    chk("rst_inst",  PR_IFID_Inst,           32'd0);
    chk("rst_pc4",   PR_IFID_PC4,            32'd0);
    chk("rst_valid", {31'd0, PR_IFID_Valid}, 32'd0);
    chk("rst_busy",  {31'd0, fetch_busy},    32'd0);
    xfer_cnt = 0;
    reset = 1'b1;
    push_seq(32'h0, 5);
    lat = 1; auto_mem = 1'b1;
    tick();
    chk("s1_first_req",   {31'd0, imem_req},      32'd1);
    chk("s1_first_valid", {31'd0, PR_IFID_Valid}, 32'd0);
    tick();
    chk("s1_addr_adv", imem_addr, 32'h4);
    wait_xfers(5);
    drain_and_check("s1");

    // ---------------- two-cycle latency ----------------
    do_reset();
    push_seq(32'h0, 3);
    lat = 2; auto_mem = 1'b1;
    tick();
    tick();
    chk("s2_addr_held",  imem_addr,              32'h0);
    chk("s2_bubble0",    {31'd0, PR_IFID_Valid}, 32'd0);
    tick();
    chk("s2_valid",      {31'd0, PR_IFID_Valid}, 32'd1);
    chk("s2_addr4",      imem_addr,              32'h4);
    tick();
    chk("s2_bubble1",    {31'd0, PR_IFID_Valid}, 32'd0);
    chk("s2_addr4_held", imem_addr,              32'h4);
    wait_xfers(3);
    drain_and_check("s2");

    // ---------------- stall with ack at 0x10 ----------------
    do_reset();
    push_seq(32'h0, 6);
    lat = 1; auto_mem = 1'b1;
    wait_xfers(4);
    stall = 1'b1;
    tick();
    chk("s3_hold_req",   {31'd0, imem_req},      32'd0);
    chk("s3_hold_busy",  {31'd0, fetch_busy},    32'd1);
    chk("s3_hold_inst",  PR_IFID_Inst,           32'h2000_000C);
    chk("s3_hold_pc4",   PR_IFID_PC4,            32'h10);
    tick();
    chk("s3_hold2_req",  {31'd0, imem_req},      32'd0);
    tick();
    stall = 1'b0;
    tick();
    chk("s3_rel_inst",   PR_IFID_Inst,           32'h2000_0010);
    chk("s3_rel_pc4",    PR_IFID_PC4,            32'h14);
    chk("s3_rel_req",    {31'd0, imem_req},      32'd1);
    chk("s3_rel_addr",   imem_addr,              32'h14);
    chk("s3_rel_busy",   {31'd0, fetch_busy},    32'd0);
    wait_xfers(6);
    drain_and_check("s3");

    // ---------------- branch while 0x20 outstanding ----------------
    do_reset();
    push_seq(32'h0, 8);
    push_xfer(32'h20);
    push_xfer(32'h40);
    push_xfer(32'h44);
    push_out(32'h2000_0040, 32'h44);
    push_out(32'h2000_0044, 32'h48);
    lat = 1; auto_mem = 1'b1;
    wait_xfers(8);
    auto_mem = 1'b0; man_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h43;
    tick();
    branch_taken = 1'b0;
    chk("s4_drop_busy",  {31'd0, fetch_busy},    32'd1);
    chk("s4_drop_req",   {31'd0, imem_req},      32'd1);
    chk("s4_drop_addr",  imem_addr,              32'h20);
    chk("s4_drop_valid", {31'd0, PR_IFID_Valid}, 32'd0);
    tick();
    chk("s4_drop_addr2", imem_addr,              32'h20);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("s4_tgt_addr",   imem_addr,              32'h40);
    chk("s4_tgt_busy",   {31'd0, fetch_busy},    32'd0);
    chk("s4_tgt_valid",  {31'd0, PR_IFID_Valid}, 32'd0);
    auto_mem = 1'b1;
    wait_xfers(11);
    drain_and_check("s4");

    // ---------------- branch and stall together in HOLD ----------------
    do_reset();
    push_seq(32'h0, 3);
    push_xfer(32'h100);
    push_xfer(32'h104);
    void'(exp_out_q.pop_back());   // word @8 goes to the skid and is discarded
    push_out(32'h2000_0100, 32'h104);
    push_out(32'h2000_0104, 32'h108);
    lat = 1; auto_mem = 1'b1;
    wait_xfers(2);
    stall = 1'b1;
    tick();
    chk("s5_hold_req",   {31'd0, imem_req},      32'd0);
    chk("s5_hold_busy",  {31'd0, fetch_busy},    32'd1);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    chk("s5_br_valid",   {31'd0, PR_IFID_Valid}, 32'd0);
    chk("s5_br_addr",    imem_addr,              32'h100);
    chk("s5_br_req",     {31'd0, imem_req},      32'd1);
    chk("s5_br_busy",    {31'd0, fetch_busy},    32'd0);
    wait_xfers(5);
    drain_and_check("s5");

    // ---------------- pc wrap, then reset mid-request ----------------
    do_reset();
    push_xfer(32'h0);
    push_xfer(32'h4);
    push_xfer(32'hFFFF_FFFC);
    push_xfer(32'h0);
    push_out(32'h2000_0000, 32'h4);
    push_out(32'hFFFF_FFFC, 32'h0);
    push_out(32'h2000_0000, 32'h4);
    lat = 1; auto_mem = 1'b1;
    wait_xfers(1);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk("s6_tgt_addr",   imem_addr,              32'hFFFF_FFFC);
    chk("s6_tgt_valid",  {31'd0, PR_IFID_Valid}, 32'd0);
    tick();
    chk("s6_wrap_pc4",   PR_IFID_PC4,            32'h0);
    chk("s6_wrap_addr",  imem_addr,              32'h0);
    wait_xfers(4);
    drain_and_check("s6");
    chk("s7_pending_req", {31'd0, imem_req},     32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    man_ack = 1'b1;                // late ack for the abandoned request
    chk("s7_req",   {31'd0, imem_req},      32'd0);
    chk("s7_addr",  imem_addr,              32'h0);
    chk("s7_inst",  PR_IFID_Inst,           32'h0);
    chk("s7_pc4",   PR_IFID_PC4,            32'h0);
    chk("s7_valid", {31'd0, PR_IFID_Valid}, 32'd0);
    chk("s7_busy",  {31'd0, fetch_busy},    32'd0);
    tick();
    man_ack = 1'b0;
    chk("s7_late_valid", {31'd0, PR_IFID_Valid}, 32'd0);
    chk("s7_late_pc4",   PR_IFID_PC4,            32'h0);
    chk("s7_restart_req", {31'd0, imem_req},     32'd1);
    chk("s7_restart_addr", imem_addr,            32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
